// File: rtl/multi_cycle_divider_pkg.sv
// Shared definitions for the ALU and its iterative divider: default divider
// width, divider FSM state encodings and the ALU operation codes.
package multi_cycle_divider_pkg;

  localparam int DivWidth = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9,
    ALU_MUL  = 5'd10,
    ALU_DIV  = 5'd11,
    ALU_DIVU = 5'd12,
    ALU_REM  = 5'd13,
    ALU_REMU = 5'd14
  } alu_op_e;

  // The ALU uses these to route an op to the divider and pick signedness.
  function automatic logic alu_op_is_div(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic alu_op_div_signed(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/multi_cycle_divider.sv
// Radix-2 restoring divider: one quotient bit per cycle on operand magnitudes,
// with signs re-applied on the final iteration so results land registered.
module multi_cycle_divider
  import multi_cycle_divider_pkg::*;
#(
  parameter int WIDTH = DivWidth,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             div_en_i,
  input  logic             div_sign_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             complete_o,
  output logic             busy_o
);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_acc_q;
  logic [WIDTH-1:0] quo_acc_q;
  logic [WIDTH-1:0] dvs_q;
  logic             quo_neg_q;
  logic             rem_neg_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic             x_neg_d;
  logic             y_neg_d;
  logic [WIDTH-1:0] x_mag_d;
  logic [WIDTH-1:0] y_mag_d;
  logic [WIDTH:0]   r_shift_d;
  logic [WIDTH:0]   diff_d;
  logic             step_ok_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] quotient_d;
  logic [WIDTH-1:0] remainder_d;

  // Magnitudes wrap modulo 2^WIDTH, so MIN stays MIN and MIN/-1 needs no special case.
  always_comb begin
    x_neg_d = div_sign_i & dividend_i[WIDTH-1];
    y_neg_d = div_sign_i & divisor_i[WIDTH-1];
    x_mag_d = x_neg_d ? -dividend_i : dividend_i;
    y_mag_d = y_neg_d ? -divisor_i  : divisor_i;
  end

  // One restoring step: shift in the next dividend bit, keep the difference if it fits.
  always_comb begin
    r_shift_d   = {rem_acc_q, quo_acc_q[WIDTH-1]};
    diff_d      = r_shift_d - {1'b0, dvs_q};
    step_ok_d   = ~diff_d[WIDTH];
    rem_d       = step_ok_d ? diff_d[WIDTH-1:0] : r_shift_d[WIDTH-1:0];
    quo_d       = {quo_acc_q[WIDTH-2:0], step_ok_d};
    quotient_d  = quo_neg_q ? -quo_d : quo_d;
    remainder_d = rem_neg_q ? -rem_d : rem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_acc_q   <= '0;
      quo_acc_q   <= '0;
      dvs_q       <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_en_i) begin
            if (divisor_i == '0) begin
              quotient_q  <= '1;
              remainder_q <= dividend_i;
              state_q     <= DONE;
            end else begin
              rem_acc_q <= '0;
              quo_acc_q <= x_mag_d;
              dvs_q     <= y_mag_d;
              quo_neg_q <= x_neg_d ^ y_neg_d;
              rem_neg_q <= x_neg_d;
              cnt_q     <= CNT_W'(WIDTH);
              state_q   <= DIV;
            end
          end
        end
        DIV: begin
          rem_acc_q <= rem_d;
          quo_acc_q <= quo_d;
          cnt_q     <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            state_q     <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign complete_o  = (state_q == DONE);
  assign busy_o      = (state_q == DIV) || (state_q == DONE);

endmodule

// File: tb/tb_multi_cycle_divider.sv
// Scoreboard bench for multi_cycle_divider at WIDTH=32: reference results come
// from native SystemVerilog arithmetic with explicit zero and MIN/-1 handling.
module tb_multi_cycle_divider;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush_i = 1'b0;
  logic         div_en_i = 1'b0;
  logic         div_sign_i = 1'b0;
  logic [W-1:0] dividend_i = '0;
  logic [W-1:0] divisor_i = '0;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         complete_o;
  logic         busy_o;

  int           n_checks = 0;
  int           n_fail = 0;
  exp_t         sb[$];
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  multi_cycle_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .div_en_i    (div_en_i),
    .div_sign_i  (div_sign_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .complete_o  (complete_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   sx;
    int   sy;
    if (y == '0) begin
      e.q = '1; e.r = x; e.lat = 1;
    end else if (!s) begin
      e.q = x / y; e.r = x % y; e.lat = W + 1;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.q = x; e.r = '0; e.lat = W + 1;
    end else begin
      sx = x; sy = y;
      e.q = sx / sy; e.r = sx % sy; e.lat = W + 1;
    end
    return e;
  endfunction

  // Caller sits at a negedge; operands are scrambled right after the start edge.
  task automatic drive_start(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    div_en_i = 1'b1; div_sign_i = s; dividend_i = x; divisor_i = y;
    @(posedge clk); #1;
    div_en_i = 1'b0; div_sign_i = ~s; dividend_i = $urandom; divisor_i = $urandom;
  endtask

  task automatic start_div(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    sb.push_back(model(s, x, y));
    drive_start(s, x, y);
  endtask

  task automatic wait_result(input string name);
    exp_t e;
    int   lat;
    bit   seen;
    e = sb.pop_front();
    lat = 0; seen = 0;
    while (!seen && lat < 100) begin
      @(negedge clk); lat++;
      if (complete_o) seen = 1;
      else begin
        n_checks++;
        if (quotient_o !== last_q || remainder_o !== last_r || busy_o !== 1'b1) begin
          n_fail++;
          $display("FAIL %s hold/busy: q=%h r=%h busy=%b, required q=%h r=%h busy=1",
                   name, quotient_o, remainder_o, busy_o, last_q, last_r);
        end
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: no complete_o within 100 cycles", name);
    end else begin
      if (lat != e.lat || quotient_o !== e.q || remainder_o !== e.r) begin
        n_fail++;
        $display("FAIL %s result: lat=%0d q=%h r=%h, required lat=%0d q=%h r=%h",
                 name, lat, quotient_o, remainder_o, e.lat, e.q, e.r);
      end else
        $display("ok   %s: lat=%0d q=%h r=%h", name, lat, quotient_o, remainder_o);
    end
    last_q = e.q; last_r = e.r;
    @(negedge clk);
    n_checks++;
    if (complete_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s pulse: complete=%b busy=%b, required 0/0", name, complete_o, busy_o);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (quotient_o !== '0 || remainder_o !== '0 || complete_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: q=%h r=%h c=%b b=%b, required all 0",
               quotient_o, remainder_o, complete_o, busy_o);
    end else $display("ok   reset_state");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    start_div(1'b0, 32'd100, 32'd7);          wait_result("udiv_100_7");
    start_div(1'b0, 32'd5, 32'd9);            wait_result("udiv_small");
    start_div(1'b0, 32'hFFFF_FFFF, 32'd1);    wait_result("udiv_max_1");
  endtask

  task automatic test_signed();
    start_div(1'b1, 32'hFFFF_FFF9, 32'd2);          wait_result("sdiv_m7_2");
    start_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);  wait_result("sdiv_min_m1");
    start_div(1'b1, 32'd7, 32'hFFFF_FFFE);          wait_result("sdiv_7_m2");
    start_div(1'b1, 32'h8000_0000, 32'd3);          wait_result("sdiv_min_3");
  endtask

  task automatic test_div_zero();
    start_div(1'b0, 32'd5, 32'd0);           wait_result("udiv_zero");
    start_div(1'b1, 32'hFFFF_FF00, 32'd0);   wait_result("sdiv_zero");
  endtask

  task automatic test_flush();
    bit bad;
    bad = 0;
    drive_start(1'b0, 32'd100, 32'd7);
    repeat (9) begin
      @(negedge clk);
      if (complete_o) bad = 1;
    end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bad || busy_o !== 1'b0 || complete_o !== 1'b0 ||
        quotient_o !== last_q || remainder_o !== last_r) begin
      n_fail++;
      $display("FAIL flush_mid: busy=%b complete=%b q=%h r=%h, required 0/0 q=%h r=%h",
               busy_o, complete_o, quotient_o, remainder_o, last_q, last_r);
    end else $display("ok   flush_mid");
    start_div(1'b0, 32'd9, 32'd3); wait_result("after_flush_9_3");
    // flush and start in the same idle cycle: no division may start
    flush_i = 1'b1; div_en_i = 1'b1; div_sign_i = 1'b0; dividend_i = 32'd8; divisor_i = 32'd2;
    @(posedge clk); #1;
    flush_i = 1'b0; div_en_i = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy_o || complete_o) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL flush_vs_start: busy/complete seen, required neither");
    end else $display("ok   flush_vs_start");
  endtask

  task automatic test_reset_mid();
    bit bad;
    drive_start(1'b0, 32'd1000, 32'd3);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (quotient_o !== '0 || remainder_o !== '0 || complete_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: q=%h r=%h c=%b b=%b, required all 0",
               quotient_o, remainder_o, complete_o, busy_o);
    end else $display("ok   reset_mid");
    @(negedge clk);
    rst = 1'b0;
    last_q = '0; last_r = '0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (complete_o || busy_o) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_no_complete: complete/busy seen after reset, required none");
    end else $display("ok   reset_no_complete");
  endtask

  task automatic test_back_to_back();
    start_div(1'b0, 32'hFFFF_FFFF, 32'h10); wait_result("b2b_first");
    start_div(1'b0, 32'hFFFF_FFFF, 32'h10); wait_result("b2b_second");
  endtask

  task automatic test_random();
    logic         s;
    logic [W-1:0] x;
    logic [W-1:0] y;
    for (int i = 0; i < 12; i++) begin
      s = $urandom_range(0, 1);
      x = $urandom;
      y = (i % 3 == 0) ? W'($urandom_range(1, 255)) : W'($urandom);
      if (i == 5) y = '0;
      start_div(s, x, y);
      wait_result($sformatf("rand_%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
